// File: rtl/elevator_pkg.sv
// Shared direction and state codes for the elevator controller blocks.
// dir_flip gives the opposite travel direction for the SCAN reversal.
package elevator_pkg;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b10,
    DIR_DOWN = 2'b01
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MOVE = 2'b01,
    ST_DOOR = 2'b10
  } state_e;

  function automatic dir_e dir_flip(input dir_e d);
    return (d == DIR_UP) ? DIR_DOWN : DIR_UP;
  endfunction

endpackage

// File: rtl/elevator_req_scan.sv
// Combinational summary of the pending-request mask relative to the car:
// any request above, any below, and one at the current floor.
module elevator_req_scan #(
  parameter int N_FLOORS = 8,
  parameter int FLOOR_W  = $clog2(N_FLOORS)
) (
  input  logic [N_FLOORS-1:0] pending_i,
  input  logic [FLOOR_W-1:0]  floor_i,
  output logic                above_o,
  output logic                below_o,
  output logic                here_o
);

  always_comb begin
    above_o = 1'b0;
    below_o = 1'b0;
    here_o  = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (i > int'(floor_i))  above_o = above_o | pending_i[i];
      if (i < int'(floor_i))  below_o = below_o | pending_i[i];
      if (i == int'(floor_i)) here_o  = here_o  | pending_i[i];
    end
  end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN elevator car controller: pending request mask, timed floor moves and
// timed (reloadable) door dwell. emergency asynchronously recalls to floor 0.
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int N_FLOORS    = 8,
  parameter int FLOOR_W     = $clog2(N_FLOORS),
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 6
) (
  input  logic                clk,
  input  logic                emergency,
  input  logic                req_valid,
  input  logic [FLOOR_W-1:0]  req_floor,
  output logic                req_ready,
  output logic                req_err,
  output logic [FLOOR_W-1:0]  floor,
  output logic [1:0]          dir,
  output logic                moving,
  output logic                door_open,
  output logic [N_FLOORS-1:0] pending,
  output logic [1:0]          state
);

  localparam int TMAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_CYCLES - 1);

  // Handshake: a request transfers on any clock edge where req_valid and
  // req_ready are both high; req_ready drops only while emergency is held.
  state_e                state_q, state_d;
  dir_e                  dir_q, dir_d;
  dir_e                  last_dir_q, last_dir_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [N_FLOORS-1:0]   pending_q, pending_d;
  logic                  req_err_q, req_err_d;
  logic                  moving_q, door_q;

  logic                  accept, in_range, door_reload;
  logic                  above, below, here;
  logic                  ahead_last, behind_last, ahead_dir;
  logic [FLOOR_W-1:0]    next_floor;
  logic                  next_hit;
  logic [N_FLOORS-1:0]   set_vec, clr_vec, here_mask, next_mask;

  elevator_req_scan #(
    .N_FLOORS (N_FLOORS),
    .FLOOR_W  (FLOOR_W)
  ) u_scan (
    .pending_i (pending_q),
    .floor_i   (floor_q),
    .above_o   (above),
    .below_o   (below),
    .here_o    (here)
  );

  assign req_ready   = ~emergency;
  assign accept      = req_valid & req_ready;
  assign in_range    = int'(req_floor) < N_FLOORS;
  assign door_reload = accept & in_range & (state_q == ST_DOOR) & (req_floor == floor_q);
  assign ahead_last  = (last_dir_q == DIR_UP) ? above : below;
  assign behind_last = (last_dir_q == DIR_UP) ? below : above;
  // Only consulted when the arrival floor has no request, so the mask beyond
  // the old floor equals the mask beyond the new one.
  assign ahead_dir   = (dir_q == DIR_UP) ? above : below;
  assign next_floor  = (dir_q == DIR_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

  always_comb begin
    set_vec   = '0;
    here_mask = '0;
    next_mask = '0;
    next_hit  = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (accept && in_range && !door_reload && i == int'(req_floor)) set_vec[i] = 1'b1;
      if (i == int'(floor_q)) here_mask[i] = 1'b1;
      if (i == int'(next_floor)) begin
        next_mask[i] = 1'b1;
        next_hit     = pending_q[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    last_dir_d = last_dir_q;
    floor_d    = floor_q;
    timer_d    = timer_q;
    clr_vec    = '0;
    req_err_d  = accept & ~in_range;
    case (state_q)
      ST_IDLE: begin
        dir_d = DIR_IDLE;
        if (here) begin
          state_d = ST_DOOR;
          timer_d = DOOR_LOAD;
          clr_vec = here_mask;
        end else if (ahead_last) begin
          state_d = ST_MOVE;
          dir_d   = last_dir_q;
          timer_d = MOVE_LOAD;
        end else if (behind_last) begin
          state_d = ST_MOVE;
          dir_d   = dir_flip(last_dir_q);
          timer_d = MOVE_LOAD;
        end
      end
      ST_MOVE: begin
        last_dir_d = dir_q;
        if (timer_q == '0) begin
          floor_d = next_floor;
          timer_d = MOVE_LOAD;
          if (next_hit) begin
            state_d = ST_DOOR;
            dir_d   = DIR_IDLE;
            timer_d = DOOR_LOAD;
            clr_vec = next_mask;
          end else if (!ahead_dir) begin
            state_d = ST_IDLE;
            dir_d   = DIR_IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_DOOR: begin
        dir_d = DIR_IDLE;
        if (door_reload) begin
          timer_d = DOOR_LOAD;
        end else if (timer_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        dir_d   = DIR_IDLE;
      end
    endcase
    // A bit set and served on the same edge counts as served.
    pending_d = (pending_q | set_vec) & ~clr_vec;
  end

  always_ff @(posedge clk or posedge emergency) begin
    if (emergency) begin
      state_q    <= ST_IDLE;
      dir_q      <= DIR_IDLE;
      last_dir_q <= DIR_UP;
      floor_q    <= '0;
      timer_q    <= '0;
      pending_q  <= '0;
      req_err_q  <= 1'b0;
      moving_q   <= 1'b0;
      door_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      last_dir_q <= last_dir_d;
      floor_q    <= floor_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      req_err_q  <= req_err_d;
      moving_q   <= (state_d == ST_MOVE);
      door_q     <= (state_d == ST_DOOR);
    end
  end

  assign req_err   = req_err_q;
  assign floor     = floor_q;
  assign dir       = dir_q;
  assign moving    = moving_q;
  assign door_open = door_q;
  assign pending   = pending_q;
  assign state     = state_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: floor-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_elevator_scan_ctrl;
  import elevator_pkg::*;

  localparam int N  = 8;
  localparam int FW = 3;
  localparam int MC = 4;
  localparam int DC = 6;
  localparam int N2 = 6;

  logic          clk;
  logic          emergency;
  logic          req_valid;
  logic [FW-1:0] req_floor;
  logic          req_ready, req_err, moving, door_open;
  logic [FW-1:0] floor;
  logic [1:0]    dir, state;
  logic [N-1:0]  pending;

  logic          req_valid2;
  logic [2:0]    req_floor2;
  logic          req_ready2, req_err2, moving2, door_open2;
  logic [2:0]    floor2;
  logic [1:0]    dir2, state2;
  logic [N2-1:0] pending2;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 0;

  elevator_scan_ctrl #(.N_FLOORS(N), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)) dut (
    .clk(clk), .emergency(emergency), .req_valid(req_valid), .req_floor(req_floor),
    .req_ready(req_ready), .req_err(req_err), .floor(floor), .dir(dir),
    .moving(moving), .door_open(door_open), .pending(pending), .state(state)
  );

  elevator_scan_ctrl #(.N_FLOORS(N2), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)) dut2 (
    .clk(clk), .emergency(emergency), .req_valid(req_valid2), .req_floor(req_floor2),
    .req_ready(req_ready2), .req_err(req_err2), .floor(floor2), .dir(dir2),
    .moving(moving2), .door_open(door_open2), .pending(pending2), .state(state2)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: floor number, travel sign (+1/-1/0), edges left in the current activity
  int           m_floor = 0;
  bit [N-1:0]   m_pend  = '0;
  string        m_mode  = "idle";
  int           m_dir   = 0;
  int           m_last  = 1;
  int           m_left  = 0;
  bit           m_err   = 0;

  function automatic bit want(input bit [N-1:0] p, input int fl, input int d);
    for (int i = 0; i < N; i++) begin
      if (p[i] && ((d > 0 && i > fl) || (d < 0 && i < fl))) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge clk or posedge emergency) begin : model
    int fl, d, last, left, f;
    string mode;
    bit [N-1:0] p_old, p_set, p_clr;
    bit reload, err;
    if (emergency) begin
      m_floor <= 0; m_pend <= '0; m_mode <= "idle"; m_dir <= 0;
      m_last <= 1; m_left <= 0; m_err <= 0;
    end else begin
      fl = m_floor; d = m_dir; last = m_last; left = m_left; mode = m_mode;
      p_old = m_pend; p_set = '0; p_clr = '0; reload = 0;
      f = int'(req_floor);
      err = req_valid && f >= N;
      if (req_valid && f < N) begin
        if (mode == "door" && f == fl) reload = 1;
        else p_set[f] = 1'b1;
      end
      if (mode == "idle") begin
        d = 0;
        if (p_old[fl]) begin
          mode = "door"; left = DC; p_clr[fl] = 1'b1;
        end else if (want(p_old, fl, last)) begin
          mode = "move"; d = last; left = MC;
        end else if (want(p_old, fl, -last)) begin
          mode = "move"; d = -last; left = MC;
        end
      end else if (mode == "move") begin
        last = d;
        left = left - 1;
        if (left == 0) begin
          fl = fl + d;
          left = MC;
          if (p_old[fl]) begin
            mode = "door"; d = 0; left = DC; p_clr[fl] = 1'b1;
          end else if (!want(p_old, fl, d)) begin
            mode = "idle"; d = 0;
          end
        end
      end else begin
        if (reload) left = DC;
        else begin
          left = left - 1;
          if (left == 0) mode = "idle";
        end
      end
      m_floor <= fl; m_dir <= d; m_last <= last; m_left <= left; m_mode <= mode;
      m_err <= err;
      m_pend <= (p_old | p_set) & ~p_clr;
    end
  end

  function automatic logic [1:0] dir_code(input int d);
    return (d > 0) ? 2'b10 : (d < 0) ? 2'b01 : 2'b00;
  endfunction

  function automatic logic [1:0] state_code(input string s);
    return (s == "move") ? ST_MOVE : (s == "door") ? ST_DOOR : ST_IDLE;
  endfunction

  // scoreboard: per-cycle compare against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_floor",   32'(floor),     32'(m_floor));
      check("m_dir",     32'(dir),       32'(dir_code(m_dir)));
      check("m_moving",  32'(moving),    32'(m_mode == "move"));
      check("m_door",    32'(door_open), 32'(m_mode == "door"));
      check("m_pending", 32'(pending),   32'(m_pend));
      check("m_req_err", 32'(req_err),   32'(m_err));
      check("m_ready",   32'(req_ready), 32'(!emergency));
      check("m_state",   32'(state),     32'(state_code(m_mode)));
    end
  end

  // driver tasks: inputs change 2 time units after the rising edge
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_req(input int f);
    req_valid = 1'b1;
    req_floor = FW'(f);
    edges(1);
    req_valid = 1'b0;
  endtask

  task automatic send_req2(input int f);
    req_valid2 = 1'b1;
    req_floor2 = 3'(f);
    edges(1);
    req_valid2 = 1'b0;
  endtask

  task automatic wait_door(input bit want_open, input int budget, input string name);
    int k = 0;
    while (door_open !== want_open && k < budget) begin
      edges(1);
      k++;
    end
    check(name, 32'(door_open), 32'(want_open));
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (!(state === ST_IDLE && pending === '0) && k < budget) begin
      edges(1);
      k++;
    end
    check(name, 32'(state), 32'(ST_IDLE));
  endtask

  initial begin
    emergency  = 1'b1;
    req_valid  = 1'b0;
    req_floor  = '0;
    req_valid2 = 1'b0;
    req_floor2 = '0;
    #1;
    // 1: reset state
    check("rst_floor",   32'(floor),     32'd0);
    check("rst_dir",     32'(dir),       32'd0);
    check("rst_moving",  32'(moving),    32'd0);
    check("rst_door",    32'(door_open), 32'd0);
    check("rst_pending", 32'(pending),   32'd0);
    check("rst_req_err", 32'(req_err),   32'd0);
    check("rst_ready",   32'(req_ready), 32'd0);
    cmp_en = 1;
    edges(2);
    emergency = 1'b0;
    #1;
    check("rel_ready", 32'(req_ready), 32'd1);
    check("rel_state", 32'(state),     32'(ST_IDLE));

    // 4: out-of-range requests on the 6-floor instance
    edges(1);
    send_req2(7);
    check("err7_pulse",   32'(req_err2), 32'd1);
    check("err7_pending", 32'(pending2), 32'd0);
    edges(1);
    check("err7_drop",    32'(req_err2), 32'd0);
    send_req2(6);
    check("err6_pulse",   32'(req_err2), 32'd1);
    check("err6_pending", 32'(pending2), 32'd0);
    send_req2(5);
    check("ok5_err",      32'(req_err2), 32'd0);
    check("ok5_pending",  32'(pending2), 32'h20);

    // 2: floor 0 -> 3
    send_req(3);
    edges(1);
    check("t2_dir_up",  32'(dir),    32'h2);
    check("t2_moving",  32'(moving), 32'd1);
    edges(4);
    check("t2_floor1",  32'(floor),  32'd1);
    edges(4);
    check("t2_floor2",  32'(floor),  32'd2);
    edges(4);
    check("t2_floor3",  32'(floor),  32'd3);
    check("t2_door",    32'(door_open), 32'd1);
    check("t2_pend3",   32'(pending[3]), 32'd0);
    for (int k = 1; k < DC; k++) begin
      edges(1);
      check("t2_door_held", 32'(door_open), 32'd1);
    end
    edges(1);
    check("t2_door_shut", 32'(door_open), 32'd0);
    check("t2_dir_idle",  32'(dir),       32'd0);

    // return to floor 0
    send_req(0);
    wait_idle(60, "home_idle");
    check("home_floor", 32'(floor), 32'd0);

    // 3: up past 2 with {5,1} pending -> 5, reverse, 1
    send_req(5);
    edges(1);
    check("t3_moving", 32'(moving), 32'd1);
    edges(8);
    check("t3_floor2", 32'(floor), 32'd2);
    edges(1);
    send_req(1);
    wait_door(1'b1, 40, "t3_door5");
    check("t3_at5", 32'(floor), 32'd5);
    wait_door(1'b0, 20, "t3_close5");
    wait_door(1'b1, 40, "t3_door1");
    check("t3_at1", 32'(floor), 32'd1);
    wait_idle(30, "t3_idle");
    check("t3_rest1", 32'(floor), 32'd1);
    check("t3_dir",   32'(dir),   32'd0);

    // 5: reload the door at floor 4 on its third cycle
    send_req(4);
    wait_door(1'b1, 40, "t5_door");
    check("t5_at4", 32'(floor), 32'd4);
    edges(2);
    send_req(4);
    for (int k = 0; k < DC; k++) begin
      check("t5_door_held", 32'(door_open),  32'd1);
      check("t5_pend4",     32'(pending[4]), 32'd0);
      edges(1);
    end
    check("t5_door_shut", 32'(door_open), 32'd0);
    wait_idle(20, "t5_idle");

    // 6: emergency between edges mid-move
    send_req(7);
    edges(5);
    check("t6_floor5", 32'(floor), 32'd5);
    edges(1);
    emergency = 1'b1;
    #1;
    check("t6_floor0",  32'(floor),     32'd0);
    check("t6_pending", 32'(pending),   32'd0);
    check("t6_moving",  32'(moving),    32'd0);
    check("t6_ready",   32'(req_ready), 32'd0);
    edges(2);
    emergency = 1'b0;
    edges(1);
    send_req(2);
    edges(1);
    check("t6_dir_up", 32'(dir), 32'h2);
    edges(8);
    check("t6_floor2", 32'(floor),     32'd2);
    check("t6_door",   32'(door_open), 32'd1);
    wait_idle(20, "t6_idle");

    edges(2);
    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
